cdc_strobe_arbiter: RTL and testbench

CDC_STROBE_ARBITER -- requirements
Module: cdc_strobe_arbiter

---
 rtl/cdc_arb_pkg.sv | 33 +++
 rtl/cdc_strobe_arbiter_rr.sv | 47 ++++
 rtl/cdc_strobe_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_cdc_strobe_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_arb_pkg
// Description : Shared types and default constants for the strobe arbiter
//               that multiplexes several requesters onto one handshake
//               channel.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_arb_pkg;

  // Default configuration of the arbiter
  localparam int C_DEFAULT_NUM_REQ   = 4;
  localparam int C_DEFAULT_CNT_W     = 4;
  localparam int C_DEFAULT_TO_CYCLES = 8;

  // Handshake sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_e;

  // Width needed to count 0..value-1, never narrower than one bit
  function automatic int clog2_min1(input int value);
    if (value <= 2) begin
      return 1;
    end
    return $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_strobe_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Scans the request vector
//               starting at the pointer position and wrapping around, and
//               returns the first active request as one-hot and as an index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N     = C_DEFAULT_NUM_REQ,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Priority scan beginning at ptr; the pointer is always below N so a
  // single conditional subtract is enough to wrap the candidate index.
  always_comb begin
    int   cand;
    logic found;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdc_strobe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_strobe_arbiter
// Description : Shares one source-domain strobe/stall handshake channel
//               between NUM_REQ event requesters. Each requester owns a
//               saturating pending-event counter; a round-robin sequencer
//               issues one channel strobe per pending event and waits for the
//               stall pulse of the far side before issuing the next one.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_strobe_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ   = C_DEFAULT_NUM_REQ,
  parameter int CNT_W     = C_DEFAULT_CNT_W,
  parameter int TO_CYCLES = C_DEFAULT_TO_CYCLES
) (
  input  logic                       source_clk,
  input  logic                       source_reset,
  input  logic [NUM_REQ-1:0]         req_strobe,
  input  logic                       ovf_clr,
  input  logic                       ch_stall,
  output logic                       ch_strobe,
  output logic [$clog2(NUM_REQ)-1:0] ch_grant_id,
  output logic [NUM_REQ-1:0]         req_busy,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_overflow,
  output logic                       ch_error
);

  localparam int                ID_W     = $clog2(NUM_REQ);
  localparam int                TO_W     = clog2_min1(TO_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYCLES - 1);
  localparam logic [ID_W-1:0]   LAST_IDX = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  // Sequencer state and registered outputs
  arb_state_e         state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [NUM_REQ-1:0] grant_oh_q;
  logic [NUM_REQ-1:0] done_q;
  logic               strobe_q;
  logic               error_q;
  logic [TO_W-1:0]    to_cnt_q;

  // Counter bank and overflow tracking
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] dec_vec;
  logic [NUM_REQ-1:0] ovf_set;
  logic [NUM_REQ-1:0] ovf_d;
  logic [NUM_REQ-1:0] ovf_q;

  // Round-robin selection results
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;

  // The winner's counter is consumed in the single ISSUE cycle only
  assign dec_vec = (state_q == ST_ISSUE) ? grant_oh_q : '0;

  // --------------------------------------------------------------------------
  // Per-requester pending-event counters
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_drop;

    // Count up on a strobe, down on a grant; both together cancel out. A
    // strobe that would wrap a full counter is dropped and flagged.
    always_comb begin
      cnt_d    = cnt_q;
      sat_drop = 1'b0;
      case ({req_strobe[gi], dec_vec[gi]})
        2'b10: begin
          if (cnt_q == CNT_MAX) begin
            sat_drop = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Counter register; strobes seen during reset are discarded
    always_ff @(posedge source_clk) begin
      if (source_reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy[gi]    = |cnt_q;
    assign ovf_set[gi] = sat_drop;
  end

  // Sticky overflow: a fresh saturation wins over a same-cycle clear
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~{NUM_REQ{ovf_clr}});
  end

  // Overflow flag register
  always_ff @(posedge source_clk) begin
    if (source_reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin selection over requesters with pending events
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req         (busy),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // --------------------------------------------------------------------------
  // Handshake sequencer: one strobe in flight, wait for stall high then low
  // --------------------------------------------------------------------------
  always_ff @(posedge source_clk) begin
    if (source_reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      grant_oh_q <= '0;
      strobe_q   <= 1'b0;
      done_q     <= '0;
      error_q    <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          // Only start when the channel is quiet so the strobe is not lost
          if (!ch_stall && arb_valid) begin
            state_q    <= ST_ISSUE;
            strobe_q   <= 1'b1;
            grant_id_q <= arb_idx;
            grant_oh_q <= arb_grant;
            rr_ptr_q   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + ID_W'(1);
          end
        end
        ST_ISSUE: begin
          state_q  <= ST_WAIT_HI;
          to_cnt_q <= '0;
        end
        ST_WAIT_HI: begin
          if (ch_stall) begin
            state_q <= ST_WAIT_LO;
          end else if (to_cnt_q == TO_LAST) begin
            // Far side never acknowledged: give up without a completion
            state_q <= ST_IDLE;
            error_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!ch_stall) begin
            state_q <= ST_IDLE;
            done_q  <= grant_oh_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_strobe    = strobe_q;
  assign ch_grant_id  = grant_id_q;
  assign req_busy     = busy;
  assign req_done     = done_q;
  assign req_overflow = ovf_q;
  assign ch_error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_strobe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_strobe_arbiter
// Description : Scoreboard bench. Stimulus pushes the expected grant/done
//               sequence derived from a pending-count model; a monitor pops
//               and compares whenever the DUT strobes or completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_strobe_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int CNT_W     = 4;
  localparam int TO_CYCLES = 8;
  localparam int ID_W      = 2;
  localparam int CNT_MAX   = 15;

  logic               source_clk = 1'b0;
  logic               source_reset;
  logic [NUM_REQ-1:0] req_strobe;
  logic               ovf_clr;
  logic               ch_stall;
  logic               ch_strobe;
  logic [ID_W-1:0]    ch_grant_id;
  logic [NUM_REQ-1:0] req_busy;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] req_overflow;
  logic               ch_error;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_grant_q[$];
  int exp_done_q[$];

  // Abstract model: pending events per requester, sticky overflow, next start
  int m_cnt[NUM_REQ];
  int m_ovf[NUM_REQ];
  int m_ptr;

  int stall_mode;  // 0 auto handshake, 1 held high, 2 stuck low
  int rise_dly;
  int fall_dly;

  cdc_strobe_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .CNT_W     (CNT_W),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .source_clk   (source_clk),
    .source_reset (source_reset),
    .req_strobe   (req_strobe),
    .ovf_clr      (ovf_clr),
    .ch_stall     (ch_stall),
    .ch_strobe    (ch_strobe),
    .ch_grant_id  (ch_grant_id),
    .req_busy     (req_busy),
    .req_done     (req_done),
    .req_overflow (req_overflow),
    .ch_error     (ch_error)
  );

  always #5 source_clk = ~source_clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] model_ovf_vec();
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) v[i] = (m_ovf[i] != 0);
    return v;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_busy_vec();
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  // One cycle of strobes/clear applied to the model (no grants in flight)
  task automatic model_apply(input logic [NUM_REQ-1:0] vec, input bit clr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (clr) m_ovf[i] = 0;
      if (vec[i]) begin
        if (m_cnt[i] == CNT_MAX) m_ovf[i] = 1;
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  // Serve every pending event in round-robin order, queueing expectations
  task automatic model_drain(input bit with_done);
    bit any;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (!any && m_cnt[idx] > 0) begin
          any = 1'b1;
          m_cnt[idx] = m_cnt[idx] - 1;
          exp_grant_q.push_back(idx);
          if (with_done) exp_done_q.push_back(idx);
          m_ptr = (idx + 1) % NUM_REQ;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic pulse(input logic [NUM_REQ-1:0] vec, input bit clr);
    @(negedge source_clk);
    req_strobe = vec;
    ovf_clr    = clr;
    model_apply(vec, clr);
    @(negedge source_clk);
    req_strobe = '0;
    ovf_clr    = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((exp_grant_q.size() != 0 || exp_done_q.size() != 0) && n < bound) begin
      @(posedge source_clk);
      #1;
      n++;
    end
    check("drain_complete", (exp_grant_q.size() == 0 && exp_done_q.size() == 0), 1);
    repeat (2) @(posedge source_clk);
    #1;
  endtask

  task automatic wait_strobe(input int bound);
    int n;
    n = 0;
    do begin
      @(posedge source_clk);
      #1;
      n++;
    end while (!ch_strobe && n < bound);
    check("strobe_seen", ch_strobe, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ch_strobe"}, ch_strobe, 0);
    check({tag, "_grant_id"}, ch_grant_id, 0);
    check({tag, "_busy"}, req_busy, 0);
    check({tag, "_done"}, req_done, 0);
    check({tag, "_overflow"}, req_overflow, 0);
    check({tag, "_ch_error"}, ch_error, 0);
  endtask

  // Far-side channel model driving ch_stall
  initial begin
    ch_stall = 1'b0;
    forever begin
      @(negedge source_clk);
      if (stall_mode == 1) begin
        ch_stall = 1'b1;
      end else if (stall_mode == 2) begin
        ch_stall = 1'b0;
      end else begin
        ch_stall = 1'b0;
        if (ch_strobe) begin
          repeat (rise_dly) @(negedge source_clk);
          ch_stall = 1'b1;
          repeat (fall_dly) @(negedge source_clk);
          ch_stall = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every strobe and completion against the scoreboard
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge source_clk);
      #1;
      if (ch_strobe) begin
        check("strobe_single_cycle", prev, 0);
        check("grant_expected", exp_grant_q.size() > 0, 1);
        if (exp_grant_q.size() > 0) begin
          int e;
          e = exp_grant_q.pop_front();
          check("grant_id", ch_grant_id, e);
        end
      end
      prev = ch_strobe;
      if (req_done != '0) begin
        check("done_onehot", $onehot(req_done), 1);
        check("done_expected", exp_done_q.size() > 0, 1);
        if (exp_done_q.size() > 0) begin
          int e;
          e = exp_done_q.pop_front();
          check("done_vector", req_done, longint'(1) << e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    req_strobe   = '0;
    ovf_clr      = 1'b0;
    source_reset = 1'b1;
    stall_mode   = 0;
    rise_dly     = 2;
    fall_dly     = 3;
    model_reset();

    repeat (3) @(posedge source_clk);
    #1;
    check_all_zero("reset");
    @(negedge source_clk);
    source_reset = 1'b0;
    repeat (2) @(posedge source_clk);
    #1;

    // Three simultaneous requesters served 0, 1, 3
    pulse(4'b1011, 1'b0);
    model_drain(1'b1);
    wait_idle(300);

    // Single strobe on requester 2: strobe two cycles later, id held after
    rise_dly = 2;
    fall_dly = 6;
    @(negedge source_clk);
    req_strobe = 4'b0100;
    model_apply(4'b0100, 1'b0);
    model_drain(1'b1);
    @(posedge source_clk);
    #1;
    check("latency_t1_quiet", ch_strobe, 0);
    @(negedge source_clk);
    req_strobe = '0;
    @(posedge source_clk);
    #1;
    check("latency_t2_strobe", ch_strobe, 1);
    check("latency_grant_id", ch_grant_id, 2);
    wait_idle(100);
    check("grant_id_held", ch_grant_id, 2);

    // Strobe on requester 1 coinciding with its own grant keeps it pending
    @(negedge source_clk);
    req_strobe = 4'b0010;
    model_apply(4'b0010, 1'b0);
    model_drain(1'b1);
    @(posedge source_clk);
    #1;
    @(negedge source_clk);
    req_strobe = '0;
    @(posedge source_clk);
    #1;
    check("coincide_issue", ch_strobe, 1);
    @(negedge source_clk);
    req_strobe = 4'b0010;
    model_apply(4'b0010, 1'b0);
    model_drain(1'b1);
    @(posedge source_clk);
    #1;
    check("coincide_busy_kept", req_busy[1], 1);
    @(negedge source_clk);
    req_strobe = '0;
    wait_idle(200);
    check("coincide_busy_clear", req_busy, 0);

    // Saturation on requester 0 while the channel is stalled
    stall_mode = 1;
    repeat (2) @(negedge source_clk);
    for (int i = 0; i < 17; i++) pulse(4'b0001, 1'b0);
    check("sat_busy", req_busy, 4'b0001);
    check("sat_overflow", req_overflow, model_ovf_vec());
    pulse(4'b0000, 1'b1);
    check("ovf_clear", req_overflow, model_ovf_vec());
    pulse(4'b0001, 1'b1);
    check("ovf_clear_vs_set", req_overflow, model_ovf_vec());
    model_drain(1'b1);
    stall_mode = 0;
    wait_idle(2000);
    check("sat_overflow_kept", req_overflow, model_ovf_vec());

    // Stall never rises: timeout, error, no completion
    stall_mode = 2;
    pulse(4'b1000, 1'b0);
    model_drain(1'b0);
    wait_strobe(10);
    begin
      int n;
      n = 0;
      while (!ch_error && n < 20) begin
        @(posedge source_clk);
        #1;
        n++;
      end
      check("timeout_cycles", n, TO_CYCLES + 1);
    end
    check("timeout_error", ch_error, 1);
    stall_mode = 0;
    repeat (4) @(posedge source_clk);
    #1;
    check("error_sticky", ch_error, 1);
    check("timeout_queue_empty", exp_grant_q.size(), 0);

    // Reset while waiting for stall to fall abandons the handshake
    rise_dly = 2;
    fall_dly = 6;
    pulse(4'b0100, 1'b0);
    model_drain(1'b1);
    wait_strobe(10);
    repeat (4) @(posedge source_clk);
    #1;
    check("midreset_stall_high", ch_stall, 1);
    @(negedge source_clk);
    source_reset = 1'b1;
    req_strobe   = 4'b1111;
    exp_grant_q.delete();
    exp_done_q.delete();
    model_reset();
    @(posedge source_clk);
    #1;
    check_all_zero("midreset");
    @(negedge source_clk);
    source_reset = 1'b0;
    req_strobe   = '0;
    @(posedge source_clk);
    #1;
    check("reset_strobes_ignored", req_busy, 0);
    repeat (12) @(posedge source_clk);
    #1;

    // Randomized load-while-stalled / drain rounds
    for (int r = 0; r < 30; r++) begin
      int k;
      stall_mode = 1;
      rise_dly   = $urandom_range(1, 4);
      fall_dly   = $urandom_range(1, 6);
      repeat (2) @(negedge source_clk);
      k = $urandom_range(1, 20);
      for (int c = 0; c < k; c++) begin
        logic [NUM_REQ-1:0] v;
        bit                 clr;
        v   = NUM_REQ'($urandom_range(0, 15));
        clr = ($urandom_range(0, 7) == 0);
        @(negedge source_clk);
        req_strobe = v;
        ovf_clr    = clr;
        model_apply(v, clr);
      end
      @(negedge source_clk);
      req_strobe = '0;
      ovf_clr    = 1'b0;
      check("rand_busy", req_busy, model_busy_vec());
      check("rand_overflow", req_overflow, model_ovf_vec());
      model_drain(1'b1);
      stall_mode = 0;
      wait_idle(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
